// File: rtl/mul8_nibble_seq.sv
// mul8_nibble_seq: sequential 8x8 unsigned multiplier built around an external
// combinational 4x4 multiplier. Four nibble-pair passes are accumulated into a
// 16-bit product. Completion is signalled with a start/busy/done handshake and
// comes with a Z/C/N flags byte.
module mul8_nibble_seq #(
  parameter int unsigned ZERO_SKIP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  flags,
  output logic [3:0]  mul_ra,
  output logic [3:0]  mul_rb,
  input  logic [7:0]  mul_res
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;

  logic [15:0] w_addend;
  logic [15:0] w_sum;
  logic        w_zero_op;

  // Z = result is zero, C = result needs more than 8 bits, N = top bit set
  function automatic logic [7:0] calc_flags(input logic [15:0] p);
    calc_flags = {5'b00000, p[15], (p[15:8] != 8'h00), (p == 16'h0000)};
  endfunction

  assign w_zero_op = (ZERO_SKIP != 0) && ((a == 8'h00) || (b == 8'h00));

  // Nibble selection for the 4x4 multiplier, from state and latched operands only
  always_comb begin
    mul_ra = 4'h0;
    mul_rb = 4'h0;
    case (r_state)
      S_MUL0: begin mul_ra = r_a[3:0]; mul_rb = r_b[3:0]; end
      S_MUL1: begin mul_ra = r_a[7:4]; mul_rb = r_b[3:0]; end
      S_MUL2: begin mul_ra = r_a[3:0]; mul_rb = r_b[7:4]; end
      S_MUL3: begin mul_ra = r_a[7:4]; mul_rb = r_b[7:4]; end
      default: begin mul_ra = 4'h0; mul_rb = 4'h0; end
    endcase
  end

  // Partial product aligned to its nibble weight, plus running sum.
  // The largest possible total (0xFE01) fits in 16 bits, so no carry-out is kept.
  always_comb begin
    w_addend = 16'h0000;
    case (r_state)
      S_MUL0:         w_addend = {8'h00, mul_res};
      S_MUL1, S_MUL2: w_addend = {4'h0, mul_res, 4'h0};
      S_MUL3:         w_addend = {mul_res, 8'h00};
      default:        w_addend = 16'h0000;
    endcase
    w_sum = r_acc + w_addend;
  end

  // Control FSM with registered busy/done/product/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
      flags   <= 8'h00;
      r_acc   <= 16'h0000;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= 16'h0000;
            if (w_zero_op) begin
              // a zero operand needs no passes: publish a zero result at once
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              product <= 16'h0000;
              flags   <= calc_flags(16'h0000);
            end else begin
              r_state <= S_MUL0;
              busy    <= 1'b1;
            end
          end
        end
        S_MUL0: begin
          r_acc   <= w_sum;
          r_state <= S_MUL1;
        end
        S_MUL1: begin
          r_acc   <= w_sum;
          r_state <= S_MUL2;
        end
        S_MUL2: begin
          r_acc   <= w_sum;
          r_state <= S_MUL3;
        end
        S_MUL3: begin
          // final pass: result and flags come from the same completed sum
          r_acc   <= w_sum;
          product <= w_sum;
          flags   <= calc_flags(w_sum);
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Directed testbench for mul8_nibble_seq: one instance without zero-skip and
// one with, each paired with a behavioural 4x4 multiplier.
module tb_mul8_nibble_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_zs;
  logic [7:0]  a;
  logic [7:0]  b;

  logic        busy0, done0, busy_z, done_z;
  logic [15:0] prod0, prod_z;
  logic [7:0]  flags0, flags_z;
  logic [3:0]  ra0, rb0, ra_z, rb_z;
  logic [7:0]  res0, res_z;

  int n_vec;
  int n_bad;
  logic [7:0] seq [4];

  // the external combinational 4x4 multiplier
  assign res0  = {4'h0, ra0}  * {4'h0, rb0};
  assign res_z = {4'h0, ra_z} * {4'h0, rb_z};

  mul8_nibble_seq #(.ZERO_SKIP(0)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(prod0), .flags(flags0),
    .mul_ra(ra0), .mul_rb(rb0), .mul_res(res0)
  );

  mul8_nibble_seq #(.ZERO_SKIP(1)) dut_zs (
    .clk(clk), .rst(rst), .start(start_zs), .a(a), .b(b),
    .busy(busy_z), .done(done_z), .product(prod_z), .flags(flags_z),
    .mul_ra(ra_z), .mul_rb(rb_z), .mul_res(res_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check result, latency (edges from the accept edge
  // up to and including the edge entering DONE) and number of busy cycles.
  task automatic run_op(input logic sel, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] ep, input logic [7:0] ef,
                        input int elat, input int ebusy, input bit disturb,
                        input string tag);
    int cnt;
    int nbusy;
    bit got_done;
    logic d, bz;
    @(negedge clk);
    a = ia;
    b = ib;
    if (sel) start_zs = 1'b1; else start = 1'b1;
    step();
    start    = 1'b0;
    start_zs = 1'b0;
    cnt      = 1;
    nbusy    = 0;
    got_done = 1'b0;
    while (cnt <= 12) begin
      d  = sel ? done_z : done0;
      bz = sel ? busy_z : busy0;
      if (d) begin
        got_done = 1'b1;
        break;
      end
      if (bz) begin
        if (nbusy < 4) seq[nbusy] = sel ? {ra_z, rb_z} : {ra0, rb0};
        nbusy++;
        if (disturb) begin
          a     = 8'($urandom);
          b     = 8'($urandom);
          start = ~start;
        end
      end
      step();
      cnt++;
    end
    start = 1'b0;
    chk({tag, ".done"},  32'(got_done), 32'd1);
    chk({tag, ".lat"},   32'(cnt), 32'(elat));
    chk({tag, ".busyn"}, 32'(nbusy), 32'(ebusy));
    chk({tag, ".prod"},  32'(sel ? prod_z : prod0), 32'(ep));
    chk({tag, ".flags"}, 32'(sel ? flags_z : flags0), 32'(ef));
    step();
    chk({tag, ".donew"}, 32'(sel ? done_z : done0), 32'd0);
    chk({tag, ".busy2"}, 32'(sel ? busy_z : busy0), 32'd0);
  endtask

  initial begin
    int ndone;
    int first_e;
    int last_e;
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    start_zs = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    step();
    step();
    chk("rst.busy",  32'(busy0),  32'd0);
    chk("rst.done",  32'(done0),  32'd0);
    chk("rst.prod",  32'(prod0),  32'h0);
    chk("rst.flags", 32'(flags0), 32'h0);
    chk("rst.ra",    32'(ra0),    32'h0);
    chk("rst.rb",    32'(rb0),    32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'h0E, 8'h02, 16'h001C, 8'h00, 5, 4, 1'b0, "m0e02");

    run_op(1'b0, 8'hE2, 8'h02, 16'h01C4, 8'h02, 5, 4, 1'b0, "me202");
    chk("seq0", 32'(seq[0]), 32'h22);
    chk("seq1", 32'(seq[1]), 32'hE2);
    chk("seq2", 32'(seq[2]), 32'h20);
    chk("seq3", 32'(seq[3]), 32'hE0);

    // operands and start disturbed while busy must not matter
    run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, 8'h06, 5, 4, 1'b1, "mffff");
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done0) ndone++;
    end
    chk("ffff.extra_done", 32'(ndone), 32'd0);

    run_op(1'b0, 8'h00, 8'h5A, 16'h0000, 8'h01, 5, 4, 1'b0, "zero.noskip");
    run_op(1'b1, 8'h00, 8'h5A, 16'h0000, 8'h01, 1, 0, 1'b0, "zero.skip");

    // abort mid-operation with reset
    run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, 8'h06, 5, 4, 1'b0, "pre_abort");
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 2; i++) begin
      if (done0) ndone++;
      step();
    end
    chk("abort.inmul2", 32'(busy0), 32'd1);
    chk("abort.ra_mul2", 32'({ra0, rb0}), 32'h23);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.busy",  32'(busy0),  32'd0);
    chk("abort.prod",  32'(prod0),  32'h0);
    chk("abort.flags", 32'(flags0), 32'h0);
    chk("abort.idle",  32'({ra0, rb0}), 32'h00);
    for (int i = 0; i < 6; i++) begin
      if (done0) ndone++;
      step();
    end
    chk("abort.nodone", 32'(ndone), 32'd0);
    run_op(1'b0, 8'h12, 8'h34, 16'h03A8, 8'h02, 5, 4, 1'b0, "m1234");

    // start held high for 12 cycles: re-issue on every return to IDLE
    @(negedge clk);
    a       = 8'h10;
    b       = 8'h10;
    start   = 1'b1;
    ndone   = 0;
    first_e = -1;
    last_e  = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 12) start = 1'b0;
      if (done0) begin
        ndone++;
        if (first_e < 0) first_e = i;
        last_e = i;
        chk("hold.prod",  32'(prod0),  32'h0100);
        chk("hold.flags", 32'(flags0), 32'h02);
      end
    end
    chk("hold.ndone", 32'(ndone), 32'd2);
    chk("hold.first", 32'(first_e), 32'd5);
    chk("hold.gap",   32'(last_e - first_e), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
